muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle integer multiply/divide unit in the execute stage. It performs MULT, MULTU, DIV and DIVU on two 32-bit operands and delivers the 64-bit {hi, lo} result with a one-cycle write strobe. That result/strobe pair drives the HI/LO register file's 64-bit write port directly. While an operation is in flight, the unit stalls the pipeline.

## Interface
Parameters:
- none; the operand width is fixed at 32 and the result width at 64.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `startE`  in  1  launches an operation; sampled only in IDLE.
- `opE`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcaE`  in  32  multiplicand / dividend.
- `srcbE`  in  32  multiplier / divisor.
- `flushE`  in  1  synchronous cancel of any operation in flight.
- `stallE`  out  1  pipeline hold request.
- `muldiv_result`  out  64  {hi, lo}.
  - Multiply: full 64-bit product.
  - Divide: hi = remainder, lo = quotient.
- `muldiv_valid`  out  1  one-cycle pulse; HI/LO write enable.

## Operation
- State machine with four states: IDLE, MUL, DIV, DONE.
- IDLE
  - When `startE` is 1 and `flushE` is 0, latch `opE`, the operand absolute values (signed ops only) and the result signs.
  - A multiply goes to MUL.
  - A divide with `srcbE` == 0 goes to DONE with result {srcaE, 32'hFFFF_FFFF}, for signed and unsigned alike.
  - Any other divide loads the divider and goes to DIV.
- MUL
  - Multiplies |a| by |b| as four registered 16x16 partial products, then sums them.
  - Negates the product when the operand signs differ (signed op only).
  - Goes to DONE.
- DIV
  - Radix-2 restoring divide producing one quotient bit per cycle.
  - A 5-bit counter runs 0 to 31; after the 32nd iteration, go to DONE.
  - Sign fix on exit: quotient truncates toward zero; the remainder takes the sign of the dividend.
- DONE
  - `muldiv_result` updates and `muldiv_valid` is 1 for exactly this cycle.
  - Goes to IDLE unconditionally.
  - `startE` is ignored in DONE; a back-to-back operation is accepted in the following IDLE cycle.
- Operand changes after the start cycle have no effect.
- `muldiv_result` holds its last value until the next DONE.
- `stallE` = (state==IDLE && `startE` && !`flushE`) || state==MUL || state==DIV.
  - `stallE` is 0 in DONE, so the pipeline advances in the same cycle as the write.
- Flush: `flushE`=1 in any state forces IDLE at the next edge. `muldiv_valid` is not asserted, and `muldiv_result` is unchanged.
- Corner case: signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0. This falls out of the 33-bit magnitude path and needs no trap.

## Timing
- Reset values: state IDLE, `muldiv_result` 0, `muldiv_valid` 0, `stallE` 0, counter 0.
- Start is accepted in cycle 0.
- Multiply: `muldiv_valid` in cycle 2, `stallE` high in cycles 0–1.
- Divide: `muldiv_valid` in cycle 33, `stallE` high in cycles 0–32.
- Divide by zero: `muldiv_valid` in cycle 1.
- `rst` asserted mid-operation returns the unit to reset values immediately. No pulse is emitted.
- `flushE` and DONE in the same cycle: the pulse still fires, because the DONE output is already committed, and the state returns to IDLE.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum (MULT/MULTU/DIV/DIVU, 2 bits).
  - `muldiv_state_t` enum.
  - Constant `DIV_ITERS` = 32.
  - Constant `DIV0_LO` = 32'hFFFF_FFFF.
- Sub-module `div_iter`: the radix-2 restoring datapath (remainder/quotient shift registers plus the 5-bit counter), with load/step/done signals controlled by the parent FSM.
- The multiplier, sign handling and FSM stay in `muldiv_unit`.

## Test plan
- MULT, -3 × 7 → `muldiv_valid` at cycle 2, result 64'hFFFF_FFFF_FFFF_FFEB; `stallE` high cycles 0–1.
- MULTU, 0xFFFF_FFFF × 0xFFFF_FFFF → result 64'hFFFF_FFFE_0000_0001.
- DIV, -7 / 2 → at cycle 33: hi 0xFFFF_FFFF (-1), lo 0xFFFF_FFFD (-3). DIVU, 7 / 2 → hi 1, lo 3.
- DIV, 0x8000_0000 / 0xFFFF_FFFF → hi 0, lo 0x8000_0000. DIVU, 5 / 0 → at cycle 1: hi 5, lo 0xFFFF_FFFF.
- Cancel and reset:
  - Start DIV, then assert `flushE` at cycle 10 → IDLE at cycle 11; no `muldiv_valid`; result unchanged.
  - `rst` pulse at cycle 5 of a divide → all outputs reset immediately.
- Back-to-back: hold `startE` high through DONE → the second operation starts in the IDLE cycle after DONE. Operand changes during DIV do not alter the result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
//   muldiv_op_t    : operation encoding carried on opE.
//   muldiv_state_t : control FSM states.
//   DIV_ITERS      : quotient bits produced by the restoring divider.
//   DIV0_LO        : low word returned for any divide by zero.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } muldiv_state_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

  // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
  // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
//   master : pipeline side, drives start/op/operands/flush, sees stall/result.
//   slave  : the unit itself.
interface muldiv_unit_if;
  import muldiv_pkg::*;

  logic        startE;
  muldiv_op_t  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stallE;
  logic [63:0] muldiv_result;
  logic        muldiv_valid;

  modport master (
    output startE, opE, srcaE, srcbE, flushE,
    input  stallE, muldiv_result, muldiv_valid
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, flushE,
    output stallE, muldiv_result, muldiv_valid
  );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider datapath (unsigned magnitudes).
//   load      : capture dividend/divisor, clear remainder and counter.
//   step      : perform one iteration, one quotient bit per cycle.
//   done      : the current step is the last one (counter at DIV_ITERS-1).
//   quo_next / rem_next : values after the current step, so the parent can
//                         commit the final result on the same edge.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quo_next,
  output logic [31:0] rem_next
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] diff;
  logic        q_bit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;

    // The partial remainder stays below the divisor, so the shifted trial
    // value minus the divisor fits in 33 signed bits; bit 32 is the borrow.
    diff     = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : {rem_q[30:0], quo_q[31]};
    quo_next = {quo_q[30:0], q_bit};
    done     = (cnt_q == 5'(DIV_ITERS - 1));

    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      rem_d = rem_next;
      quo_d = quo_next;
      cnt_d = cnt_q + 5'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the execute stage.
//   clk, rst : clock and asynchronous active-high reset.
//   bus      : muldiv_unit_if.slave -- start/op/operands/flush in,
//              stall, 64-bit {hi, lo} result and one-cycle valid strobe out.
// Multiply: operand magnitudes are split into four 16x16 partial products
// registered at start, summed and sign-corrected in MUL.
// Divide: magnitudes go through div_iter, sign-corrected on the last step.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic [31:0]   pp_ll_q, pp_ll_d, pp_lh_q, pp_lh_d;
  logic [31:0]   pp_hl_q, pp_hl_d, pp_hh_q, pp_hh_d;
  logic [63:0]   result_q, result_d;

  logic          start_ok, in_signed, neg_res, neg_rem;
  logic [31:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [63:0]   prod_mag;
  logic          div_load, div_step, div_done;
  logic [31:0]   div_quo, div_rem;

  div_iter u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quo_next (div_quo),
    .rem_next (div_rem)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    pp_ll_d  = pp_ll_q;
    pp_lh_d  = pp_lh_q;
    pp_hl_d  = pp_hl_q;
    pp_hh_d  = pp_hh_q;
    result_d = result_q;
    div_load = 1'b0;
    div_step = 1'b0;

    start_ok  = (state_q == S_IDLE) && bus.startE && !bus.flushE;
    in_signed = op_is_signed(bus.opE);
    a_mag     = mag32(bus.srcaE, in_signed);
    b_mag     = mag32(bus.srcbE, in_signed);

    // Quotient/product negative when signs differ; remainder follows dividend.
    neg_res = op_is_signed(op_q) && (sign_a_q ^ sign_b_q);
    neg_rem = op_is_signed(op_q) && sign_a_q;

    prod_mag = {pp_hh_q, 32'd0}
             + {16'd0, pp_hl_q, 16'd0}
             + {16'd0, pp_lh_q, 16'd0}
             + {32'd0, pp_ll_q};
    quo_fix  = neg_res ? (~div_quo + 32'd1) : div_quo;
    rem_fix  = neg_rem ? (~div_rem + 32'd1) : div_rem;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d     = bus.opE;
          sign_a_d = bus.srcaE[31];
          sign_b_d = bus.srcbE[31];
          pp_ll_d  = 32'(a_mag[15:0])  * 32'(b_mag[15:0]);
          pp_lh_d  = 32'(a_mag[15:0])  * 32'(b_mag[31:16]);
          pp_hl_d  = 32'(a_mag[31:16]) * 32'(b_mag[15:0]);
          pp_hh_d  = 32'(a_mag[31:16]) * 32'(b_mag[31:16]);
          if (!op_is_div(bus.opE)) begin
            state_d = S_MUL;
          end else if (bus.srcbE == 32'd0) begin
            result_d = {bus.srcaE, DIV0_LO};
            state_d  = S_DONE;
          end else begin
            div_load = 1'b1;
            state_d  = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = neg_res ? (~prod_mag + 64'd1) : prod_mag;
        state_d  = S_DONE;
      end
      S_DIV: begin
        div_step = 1'b1;
        if (div_done) begin
          result_d = {rem_fix, quo_fix};
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over any pending commit; a DONE already showing still pulses.
    if (bus.flushE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      pp_ll_q  <= '0;
      pp_lh_q  <= '0;
      pp_hl_q  <= '0;
      pp_hh_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      pp_ll_q  <= pp_ll_d;
      pp_lh_q  <= pp_lh_d;
      pp_hl_q  <= pp_hl_d;
      pp_hh_q  <= pp_hh_d;
      result_q <= result_d;
    end
  end

  assign bus.stallE        = start_ok || (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.muldiv_valid  = (state_q == S_DONE);
  assign bus.muldiv_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit. Stimulus pushes expected {hi, lo} and the
// cycle the strobe is due; a monitor pops on every muldiv_valid and compares.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] last_exp = '0;

  logic [63:0] exp_res_q[$];
  int          exp_due_q[$];
  string       exp_name_q[$];

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [63:0] res, input int due);
    exp_name_q.push_back(name);
    exp_res_q.push_back(res);
    exp_due_q.push_back(due);
    last_exp = res;
  endtask

  task automatic check_drained(input string name);
    check({name, "_drained"}, 64'(exp_res_q.size()), 64'd0);
    exp_name_q.delete();
    exp_res_q.delete();
    exp_due_q.delete();
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (!rst && bus.muldiv_valid) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse with result %h at cycle %0d, expected none",
                 bus.muldiv_result, cyc);
      end else begin
        string       nm;
        logic [63:0] er;
        int          due;
        nm  = exp_name_q.pop_front();
        er  = exp_res_q.pop_front();
        due = exp_due_q.pop_front();
        check({nm, "_result"}, bus.muldiv_result, er);
        check({nm, "_cycle"}, 64'(cyc), 64'(due));
      end
    end
  end

  // Launch one operation, scramble operands after the start cycle, and check
  // stallE every cycle until the DONE cycle at offset lat.
  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int s;
    tick();
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    s = cyc;
    push(name, exp, s + lat);
    #1;
    check({name, "_stall_c0"}, 64'(bus.stallE), 64'd1);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == 1) begin
        bus.startE = 1'b0;
        bus.opE    = muldiv_op_t'($urandom_range(0, 3));
        bus.srcaE  = $urandom;
        bus.srcbE  = $urandom;
      end
      #1;
      check($sformatf("%s_stall_c%0d", name, c), 64'(bus.stallE), (c < lat) ? 64'd1 : 64'd0);
    end
    tick();
    check_drained(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    bus.startE = 1'b0;
    bus.opE    = OP_MULT;
    bus.srcaE  = '0;
    bus.srcbE  = '0;
    bus.flushE = 1'b0;

    // Reset state
    repeat (2) tick();
    check("reset_result", bus.muldiv_result, 64'd0);
    check("reset_valid", 64'(bus.muldiv_valid), 64'd0);
    check("reset_stall", 64'(bus.stallE), 64'd0);
    rst = 1'b0;
    tick();

    // Multiply
    run_op("mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 2);
    run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2);
    run_op("mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2);

    // Divide
    run_op("div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_op("divu_7d2",    OP_DIVU,  32'd7,         32'd2,         {32'd1, 32'd3}, 33);
    run_op("div_7dm2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    run_op("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    run_op("divu_max_d1", OP_DIVU,  32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF}, 33);

    // Divide by zero
    run_op("divu_5d0",    OP_DIVU,  32'd5,         32'd0,         {32'd5, 32'hFFFF_FFFF}, 1);
    run_op("div_m4d0",    OP_DIV,   32'hFFFF_FFFC, 32'd0,         {32'hFFFF_FFFC, 32'hFFFF_FFFF}, 1);

    // Flush at cycle 10 of a divide: no pulse, result kept
    tick();
    bus.startE = 1'b1; bus.opE = OP_DIV; bus.srcaE = 32'd1000; bus.srcbE = 32'd3;
    s = cyc;
    tick();
    bus.startE = 1'b0;
    while (cyc < s + 10) tick();
    bus.flushE = 1'b1;
    tick();
    bus.flushE = 1'b0;
    #1;
    check("flush_idle_stall", 64'(bus.stallE), 64'd0);
    repeat (40) tick();
    check("flush_result_kept", bus.muldiv_result, last_exp);

    // Flush coinciding with DONE: pulse still fires
    tick();
    bus.startE = 1'b1; bus.opE = OP_MULTU; bus.srcaE = 32'd3; bus.srcbE = 32'd5;
    s = cyc;
    push("flush_in_done", 64'd15, s + 2);
    tick();
    bus.startE = 1'b0;
    tick();
    bus.flushE = 1'b1;
    #1;
    check("flush_in_done_stall", 64'(bus.stallE), 64'd0);
    tick();
    bus.flushE = 1'b0;
    check_drained("flush_in_done");

    // Reset at cycle 5 of a divide
    tick();
    bus.startE = 1'b1; bus.opE = OP_DIV; bus.srcaE = 32'd100; bus.srcbE = 32'd3;
    s = cyc;
    tick();
    bus.startE = 1'b0;
    while (cyc < s + 5) tick();
    rst = 1'b1;
    #1;
    check("midrst_stall", 64'(bus.stallE), 64'd0);
    check("midrst_valid", 64'(bus.muldiv_valid), 64'd0);
    check("midrst_result", bus.muldiv_result, 64'd0);
    last_exp = '0;
    tick();
    rst = 1'b0;
    repeat (40) tick();
    check("midrst_result_after", bus.muldiv_result, 64'd0);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    // Back-to-back: startE held through DONE; second op starts the cycle after
    tick();
    bus.startE = 1'b1; bus.opE = OP_MULT; bus.srcaE = 32'd6; bus.srcbE = 32'd7;
    s = cyc;
    push("b2b_first", 64'd42, s + 2);
    tick();
    tick();
    bus.opE = OP_MULTU; bus.srcaE = 32'h0001_0000; bus.srcbE = 32'h0001_0000;
    push("b2b_second", 64'h0000_0001_0000_0000, s + 5);
    tick();
    tick();
    bus.startE = 1'b0;
    bus.srcaE  = 32'hDEAD_BEEF;
    repeat (3) tick();
    check_drained("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
